// File: rtl/gp_cmd_fetch.sv
// gp_cmd_fetch -- graphics command list fetcher.
//
// Purpose:
//   Starts on a one-cycle gp_valid pulse from the CPU. Streams 32-bit command
//   words from memory, beginning at the word-aligned command-list address,
//   into a small FIFO. Presents them to the drawing engines together with the
//   frame base latched at start. A word whose opcode is 0x00 (STOP) ends the
//   list. Once all outstanding reads have returned, the FIFO is empty and the
//   engine is idle, gp_done pulses for one cycle.
//
// Parameters:
//   FIFO_DEPTH : command FIFO entries (power of two, >= 2)
//   MAX_OUT    : maximum outstanding memory reads (<= FIFO_DEPTH)
//   MAX_WORDS  : per-list command word limit (GP_FETCH_LIMIT_EN builds only)
//
// Optional feature macro: GP_FETCH_LIMIT_EN
//   Defined   : accepted requests are counted per list. Reaching MAX_WORDS
//               without a STOP halts fetching, sets gp_err and drains.
//   Undefined : no counter, and gp_err is tied to 0.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   gp_code, gp_frame   command list byte address, frame base (sampled at start)
//   gp_valid / gp_done  start pulse in / completion pulse out
//   busy                high from accepted start until gp_done
//   mem_req_*           read request channel (valid/ready/addr)
//   mem_resp_*          in-order read data, one per accepted request
//   cmd_valid/ready     command word handshake to the drawing engines
//   cmd_data, cmd_frame command word (opcode in [31:24]) and its frame base
//   engine_busy         drawing engine still executing
//   gp_err              list hit the word limit (limit builds only)

module gp_cmd_fetch #(
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_OUT    = 4,
  parameter int MAX_WORDS  = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] gp_code,
  input  logic [31:0] gp_frame,
  input  logic        gp_valid,
  output logic        gp_done,
  output logic        busy,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [31:0] cmd_data,
  output logic [31:0] cmd_frame,
  input  logic        engine_busy,
  output logic        gp_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // One spare bit so fifo_count + outstanding never wraps.
  localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [31:0]   ptr;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] outstanding;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_next;
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic          stop_seen;

  logic          credit;
  logic          limit_ok;
  logic          req_acc;
  logic          resp_live;
  logic          resp_stop;
  logic          push;
  logic          pop;
  logic [31:0]   head_next;

`ifdef GP_FETCH_LIMIT_EN
  logic [31:0]   req_cnt;
  logic          limit_hit;

  assign limit_ok  = (req_cnt < 32'(MAX_WORDS));
  // The accept that brings the count to MAX_WORDS ends the list.
  assign limit_hit = req_acc && (req_cnt == 32'(MAX_WORDS - 1));
`else
  logic          unused_cfg;

  assign limit_ok   = 1'b1;
  assign unused_cfg = (MAX_WORDS == 0);
  assign gp_err     = 1'b0;
`endif

  // Credit rule: every in-flight read already owns a FIFO slot, so pushes can
  // never overflow the FIFO. Both terms are register-based, so a raised request
  // can only drop when the credit itself runs out (or the list ends).
  assign credit = (outstanding < CW'(MAX_OUT)) &&
                  ((fifo_count + outstanding) < CW'(FIFO_DEPTH));

  assign mem_req_valid = (state == FETCH) && credit && limit_ok;
  assign mem_req_addr  = ptr;
  assign req_acc       = mem_req_valid && mem_req_ready;

  // Responses only count while a list is active and a read is actually owed.
  assign resp_live = mem_resp_valid && ((state == FETCH) || (state == DRAIN)) &&
                     (outstanding != '0);
  assign resp_stop = resp_live && (mem_resp_data[31:24] == 8'h00);
  // After a STOP, every later response is discarded. After a limit stop
  // (no STOP seen), in-flight words are still delivered.
  assign push      = resp_live && !resp_stop && !stop_seen;

  assign cmd_valid = (fifo_count != '0);
  assign pop       = cmd_valid && cmd_ready;

  // Head of the FIFO after this cycle's push/pop. The incoming word bypasses
  // storage when it lands in the slot that becomes the head, so it shows up on
  // cmd_data one cycle after its response.
  assign rd_next   = pop ? (rd_idx + AW'(1)) : rd_idx;
  assign head_next = (push && (rd_next == wr_idx)) ? mem_resp_data : fifo_mem[rd_next];

  // FIFO storage is pure data; emptiness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_idx] <= mem_resp_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
      rd_idx      <= '0;
      wr_idx      <= '0;
      stop_seen   <= 1'b0;
      busy        <= 1'b0;
      gp_done     <= 1'b0;
      cmd_data    <= '0;
      cmd_frame   <= '0;
`ifdef GP_FETCH_LIMIT_EN
      req_cnt     <= '0;
      gp_err      <= 1'b0;
`endif
    end else begin
      gp_done <= 1'b0;

      unique case (state)
        IDLE: begin
          if (gp_valid) begin
            ptr       <= {gp_code[31:2], 2'b00};
            cmd_frame <= gp_frame;
            busy      <= 1'b1;
            stop_seen <= 1'b0;
`ifdef GP_FETCH_LIMIT_EN
            req_cnt   <= '0;
            gp_err    <= 1'b0;
`endif
            state     <= FETCH;
          end
        end

        FETCH: begin
          if (resp_stop) begin
            stop_seen <= 1'b1;
            state     <= DRAIN;
          end
`ifdef GP_FETCH_LIMIT_EN
          else if (limit_hit) begin
            gp_err <= 1'b1;
            state  <= DRAIN;
          end
`endif
        end

        DRAIN: begin
          // A STOP may still arrive here after a limit stop; from then on
          // the remaining in-flight words are discarded.
          if (resp_stop) begin
            stop_seen <= 1'b1;
          end
          if ((outstanding == '0) && (fifo_count == '0) && !engine_busy) begin
            gp_done <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase

      // Request side: advance the fetch pointer, wrapping modulo 2^32.
      if (req_acc) begin
        ptr <= ptr + 32'd4;
`ifdef GP_FETCH_LIMIT_EN
        req_cnt <= req_cnt + 32'd1;
`endif
      end

      // Outstanding reads: an accept and a response in one cycle cancel out.
      unique case ({req_acc, resp_live})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase

      // FIFO occupancy: push+pop at any count leaves it unchanged.
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase

      if (push) begin
        wr_idx <= wr_idx + AW'(1);
      end
      rd_idx <= rd_next;

      if (push || pop) begin
        cmd_data <= head_next;
      end
    end
  end

endmodule

// File: tb/tb_gp_cmd_fetch.sv
// Testbench for gp_cmd_fetch: table of command lists driven through an
// in-order memory model, a scoreboard of expected command words, and
// hand-written reset-mid-list and (limit builds) word-limit sequences.

module tb_gp_cmd_fetch;

  localparam int FD = 8;
  localparam int MO = 4;
`ifdef GP_FETCH_LIMIT_EN
  localparam int MW = 4;
`else
  localparam int MW = 4096;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] gp_code, gp_frame;
  logic        gp_valid;
  logic        gp_done, busy;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_data, cmd_frame;
  logic        engine_busy;
  logic        gp_err;

  gp_cmd_fetch #(.FIFO_DEPTH(FD), .MAX_OUT(MO), .MAX_WORDS(MW)) dut (
    .clk(clk), .rst(rst),
    .gp_code(gp_code), .gp_frame(gp_frame), .gp_valid(gp_valid),
    .gp_done(gp_done), .busy(busy),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_frame(cmd_frame),
    .engine_busy(engine_busy), .gp_err(gp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] code;
    logic [31:0] frame;
    logic [31:0] first;    // expected first request address
    int          stop;     // index of the STOP word (large = none)
    int          exp_n;    // expected number of delivered command words
    int          exp_req;  // expected request count, -1 = not checked
    int          lat;      // extra memory latency cycles
    int          bp;       // cycles of cmd_ready=0 at list start
    int          eng;      // cycles engine_busy stays high from start
    bit          repulse;  // pulse gp_valid again mid-list
    bit          rdy_rand; // random mem_req_ready stalls
    bit          err;      // expected gp_err at completion
  } rec_t;

  rec_t tbl[5];

  int n_cmp = 0;
  int n_bad = 0;
  int cycle = 0;

  // memory / scoreboard model state
  logic [31:0] base, next_addr, exp_frame, first_seen;
  int          stop_idx, lat, bp_until, eng_until;
  bit          rdy_rand;
  logic [31:0] exp_q[$];
  logic [31:0] pend_a[$];
  int          pend_t[$];
  int          m_out, m_fifo, req_cnt, late_req, occ_bad, done_cnt, done_cycle;
  bit          m_stop, busy_at_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  function automatic logic [31:0] word_idx(input int i);
    if (i == stop_idx) return 32'h0000_0000;
    return {8'(i + 1), 24'(2 * i + 5)};
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    logic [31:0] off;
    off = (addr - base) >> 2;
    return word_idx(int'(off));
  endfunction

  task automatic model_clear();
    pend_a.delete(); pend_t.delete(); exp_q.delete();
    m_out = 0; m_fifo = 0; m_stop = 0; req_cnt = 0; late_req = 0;
    occ_bad = 0; done_cnt = 0; done_cycle = 0; busy_at_done = 1'b1;
    first_seen = 32'hxxxx_xxxx;
  endtask

  // One clock cycle: all inputs driven and outputs sampled at the falling edge.
  task automatic step();
    logic [31:0] w;
    bit          stop_before;
    @(negedge clk);
    cycle++;
    gp_valid      = 1'b0;
    cmd_ready     = (cycle >= bp_until);
    engine_busy   = (cycle < eng_until);
    mem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    stop_before   = m_stop;

    if (gp_done) begin
      done_cnt++;
      if (done_cnt == 1) begin
        done_cycle   = cycle;
        busy_at_done = busy;
      end
    end

    if (cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL cmd_unexpected: got %h, expected no command", cmd_data);
      end else begin
        check("cmd_data", cmd_data, exp_q.pop_front());
        check("cmd_frame", cmd_frame, exp_frame);
      end
      m_fifo--;
    end

    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    if (pend_a.size() > 0 && pend_t[0] <= cycle) begin
      w = word_at(pend_a.pop_front());
      void'(pend_t.pop_front());
      mem_resp_valid = 1'b1;
      mem_resp_data  = w;
      m_out--;
      if (w[31:24] == 8'h00) m_stop = 1'b1;
      else if (!m_stop)      m_fifo++;
    end

    if (mem_req_valid && mem_req_ready) begin
      if (req_cnt == 0) first_seen = mem_req_addr;
      check("req_addr", mem_req_addr, next_addr);
      next_addr = next_addr + 32'd4;
      req_cnt++;
      if (stop_before) late_req++;
      pend_a.push_back(mem_req_addr);
      pend_t.push_back(cycle + 1 + lat);
      m_out++;
    end

    if (m_out > MO || (m_out + m_fifo) > FD) occ_bad++;
  endtask

  task automatic run_list(input rec_t r);
    model_clear();
    base      = {r.code[31:2], 2'b00};
    next_addr = base;
    stop_idx  = r.stop;
    lat       = r.lat;
    rdy_rand  = r.rdy_rand;
    exp_frame = r.frame;
    for (int i = 0; i < r.exp_n; i++) exp_q.push_back(word_idx(i));
    bp_until  = cycle + 1 + r.bp;
    eng_until = cycle + r.eng;
    gp_code   = r.code;
    gp_frame  = r.frame;
    gp_valid  = 1'b1;
    step();
    check("busy_start", 32'(busy), 32'd1);
    check("gp_err_start", 32'(gp_err), 32'd0);
    if (r.repulse) begin
      step(); step();
      gp_code  = 32'h0BAD_0000;
      gp_frame = 32'h0BAD_F000;
      gp_valid = 1'b1;
    end
    for (int k = 0; k < 3000 && done_cnt == 0; k++) step();
    if (done_cnt == 0) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("busy_at_done", 32'(busy_at_done), 32'd0);
      check("out_at_done", 32'(m_out), 32'd0);
      check("sb_left", 32'(exp_q.size()), 32'd0);
      check("done_after_engine", 32'(done_cycle > eng_until), 32'd1);
      check("gp_err_done", 32'(gp_err), 32'(r.err));
      step(); step();
      check("done_pulses", 32'(done_cnt), 32'd1);
      check("busy_after", 32'(busy), 32'd0);
    end
    check("first_req", first_seen, r.first);
    check("late_req", 32'(late_req), 32'd0);
    check("occupancy_bad", 32'(occ_bad), 32'd0);
    if (r.exp_req >= 0) check("req_count", 32'(req_cnt), 32'(r.exp_req));
  endtask

  initial begin
    tbl[0] = '{code:32'h1000_1000, frame:32'h1040_0000, first:32'h1000_1000, stop:2,
               exp_n:2, exp_req:-1, lat:0, bp:0, eng:15, repulse:0, rdy_rand:0, err:0};
    tbl[1] = '{code:32'h2000_0000, frame:32'h3000_0000, first:32'h2000_0000, stop:12,
               exp_n:12, exp_req:-1, lat:0, bp:20, eng:0, repulse:1, rdy_rand:0, err:0};
    tbl[2] = '{code:32'h0000_8000, frame:32'h0000_4000, first:32'h0000_8000, stop:1,
               exp_n:1, exp_req:-1, lat:3, bp:0, eng:0, repulse:0, rdy_rand:0, err:0};
    tbl[3] = '{code:32'hFFFF_FFFA, frame:32'h0123_4567, first:32'hFFFF_FFF8, stop:3,
               exp_n:3, exp_req:-1, lat:0, bp:0, eng:0, repulse:0, rdy_rand:0, err:0};
    tbl[4] = '{code:32'h0000_0104, frame:32'hCAFE_0000, first:32'h0000_0104, stop:9,
               exp_n:9, exp_req:-1, lat:2, bp:3, eng:4, repulse:0, rdy_rand:1, err:0};

    rst = 1'b0;
    gp_code = '0; gp_frame = '0; gp_valid = 1'b0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0;
    cmd_ready = 1'b1; engine_busy = 1'b0;
    base = '0; next_addr = '0; exp_frame = '0; stop_idx = 0; lat = 0;
    bp_until = 0; eng_until = 0; rdy_rand = 0;
    model_clear();

    repeat (3) step();
    check("rst_ctrl", {28'd0, cmd_valid, busy, gp_done, mem_req_valid}, 32'd0);
    check("rst_addr", mem_req_addr, 32'd0);
    check("rst_data", cmd_data, 32'd0);
    check("rst_frame", cmd_frame, 32'd0);
    check("rst_err", 32'(gp_err), 32'd0);
    rst = 1'b1;
    step();

`ifndef GP_FETCH_LIMIT_EN
    for (int t = 0; t < 5; t++) run_list(tbl[t]);
`else
    begin
      rec_t lim;
      lim = '{code:32'h0000_2000, frame:32'h7700_0000, first:32'h0000_2000, stop:1000,
              exp_n:4, exp_req:4, lat:0, bp:0, eng:0, repulse:0, rdy_rand:0, err:1};
      run_list(lim);
      lim = '{code:32'h0000_3000, frame:32'h7800_0000, first:32'h0000_3000, stop:1,
              exp_n:1, exp_req:-1, lat:0, bp:0, eng:0, repulse:0, rdy_rand:0, err:0};
      run_list(lim);
    end
`endif

    // Reset in the middle of a list with words sitting in the FIFO.
    model_clear();
    base = 32'h00A0_0000; next_addr = base; stop_idx = 50; lat = 0; rdy_rand = 0;
    bp_until = cycle + 1000; eng_until = 0;
    gp_code = 32'h00A0_0000; gp_frame = 32'h55AA_0000; gp_valid = 1'b1;
    step();
    for (int k = 0; k < 60 && m_fifo < 3; k++) step();
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_ctrl", {28'd0, cmd_valid, busy, gp_done, mem_req_valid}, 32'd0);
    check("midrst_data", cmd_data, 32'd0);
    check("midrst_frame", cmd_frame, 32'd0);
    check("midrst_addr", mem_req_addr, 32'd0);
    model_clear();
    bp_until = 0;
    step(); step();
    rst = 1'b1;
    step();
    begin
      rec_t after;
      after = '{code:32'h0040_0010, frame:32'h0066_0000, first:32'h0040_0010, stop:2,
                exp_n:2, exp_req:-1, lat:1, bp:0, eng:2, repulse:0, rdy_rand:0, err:0};
      run_list(after);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gp_cmd_fetch.md
Name: gp_cmd_fetch

Overview:
- Graphics command front-end directly downstream of the CPU's gp_code/gp_frame/gp_valid/gp_Done interface.
- On a start pulse it streams 32-bit command words from memory, beginning at the command-list address, into a small FIFO and presents them to the drawing engines with the frame base attached.
- When the list terminates and everything has drained, it pulses gp_done back to the CPU.

Parameters:
- FIFO_DEPTH, 8, command FIFO entries; power of two, minimum 2.
- MAX_OUT, 4, maximum outstanding memory read requests; must be at most FIFO_DEPTH.
- MAX_WORDS, 4096, command-word limit per list; used only with GP_FETCH_LIMIT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- gp_code  in  32  command list base byte address.
- gp_frame  in  32  frame buffer base address.
- gp_valid  in  1  one-cycle start pulse.
- gp_done  out  1  one-cycle completion pulse.
- busy  out  1  high from accepted start until gp_done.
- mem_req_valid  out  1  read request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  32  word-aligned read address.
- mem_resp_valid  in  1  read data valid; responses return in order, one per accepted request.
- mem_resp_data  in  32  read data.
- cmd_valid  out  1  command word available.
- cmd_ready  in  1  engine accepts command.
- cmd_data  out  32  command word; [31:24] is the opcode.
- cmd_frame  out  32  frame base latched at start.
- engine_busy  in  1  drawing engine still executing.
- gp_err  out  1  limit hit; only with GP_FETCH_LIMIT_EN, otherwise tied 0.

Behaviour:
- Reset (rst low, asynchronous): state IDLE. All outputs 0: mem_req_addr, cmd_data, cmd_frame, gp_err included. FIFO emptied, outstanding count 0.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - gp_valid=1: latch ptr = {gp_code[31:2],2'b00} and cmd_frame = gp_frame; busy=1; go to FETCH.
  - First mem_req_valid is in the next cycle.
- FETCH, request issue:
  - mem_req_valid = (outstanding < MAX_OUT) && (fifo_count + outstanding < FIFO_DEPTH).
  - mem_req_addr = ptr.
  - A request is accepted when valid && ready; then ptr += 4, wrapping modulo 2^32 (0xFFFFFFFC -> 0x00000000).
  - mem_req_valid may only drop without acceptance when the credit condition goes false.
- FETCH, responses:
  - Each mem_resp_valid decrements outstanding.
  - Opcode != 0x00: data pushed to the FIFO.
  - Opcode == 0x00 (STOP): not pushed; go to DRAIN; no further requests issued.
- DRAIN:
  - Responses still in flight after STOP are decremented and discarded, never pushed.
  - Exit to DONE when outstanding==0, FIFO empty and engine_busy==0, all in the same cycle.
- DONE: gp_done=1 for exactly one cycle; busy=0 in the same cycle; next state IDLE.
- FIFO:
  - cmd_valid = !empty; cmd_data = head entry, registered.
  - Data from mem_resp_valid in cycle N is visible on cmd_valid/cmd_data in cycle N+1.
  - Pop on cmd_valid && cmd_ready.
  - Simultaneous push and pop is legal at any count, including full and empty-plus-push; count is unchanged except for empty-plus-push, which becomes 1.
  - Overflow is impossible by the credit rule.
- Simultaneous request accept and response in one cycle: outstanding unchanged.
- gp_valid outside IDLE is ignored. cmd_frame is stable throughout a list.
- Reset mid-list: immediate return to IDLE, FIFO cleared, all outputs 0. Late memory responses after reset are the memory system's responsibility.

Optional Feature:
- Macro: GP_FETCH_LIMIT_EN.
- Defined:
  - A 32-bit counter counts accepted requests per list.
  - When it reaches MAX_WORDS without a STOP: stop issuing, set gp_err=1, go to DRAIN. Non-STOP responses already in flight are still pushed.
  - gp_err holds until the next accepted gp_valid, then clears.
- Undefined: no counter; gp_err tied 0; fetch continues until STOP.

Test Plan:
- Basic list: gp_code=0x10001000, gp_frame=0x10400000, memory words 0x01000005, 0x02000007, 0x00000000, memory always ready, 1-cycle response -> cmd_data sequence 0x01000005, 0x02000007 with cmd_frame=0x10400000; STOP never presented; gp_done single pulse after engine_busy low.
- Backpressure: cmd_ready=0 for 20 cycles on a 12-word list, FIFO_DEPTH=8 -> at most 8 entries buffered; fifo_count+outstanding never exceeds 8; no word lost or duplicated after cmd_ready=1.
- Drain discard: MAX_OUT=4; STOP is the 2nd word, words 3-5 already requested -> only word 1 delivered; gp_done waits for outstanding=0.
- Unaligned and wrap: gp_code=0xFFFFFFFA -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 in order.
- Reset mid-list: rst low while FIFO holds 3 entries -> cmd_valid=0, busy=0, gp_done=0 immediately; new gp_valid after release starts cleanly at the new address.
- Limit (GP_FETCH_LIMIT_EN, MAX_WORDS=4): list with no STOP -> exactly 4 requests, gp_err=1, gp_done pulse; gp_err clears on next gp_valid.
